// File: rtl/mlp_pkg.sv
// ----------------------------------------------------------------------------
// mlp_pkg
// Shared types and sizes for the MLP bias path.
//   bias_t          : one bias word (Q-format, opaque here)
//   BIAS_DEPTH      : number of bias entries (neurons in the layer)
//   ADDR_W          : datapath read-address width
//   loader_state_e  : bias_loader control states
// ----------------------------------------------------------------------------
package mlp_pkg;

    typedef logic [15:0] bias_t;

    localparam int BIAS_DEPTH = 15;
    localparam int ADDR_W     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/regfile_bias_wr.sv
// ----------------------------------------------------------------------------
// regfile_bias_wr
// One-write / one-read bias storage array with asynchronous clear.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low clear of every entry
//   we, wa, wd   : synchronous write enable / address / data
//   ra1, rd1     : combinational read; addresses >= DEPTH read as 0
// A write lands on the clock edge, so a same-cycle read of the written
// address still returns the previous contents.
// ----------------------------------------------------------------------------
module regfile_bias_wr #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (wa < DEPTH_A)) begin
            mem_q[wa[IDX_W-1:0]] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1 < DEPTH_A) begin
            rd1 = mem_q[ra1[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/bias_loader.sv
// ----------------------------------------------------------------------------
// bias_loader
// Fills a DEPTH-entry bias array in address order from a valid/ready stream
// and exposes the combinational read port used by the MLP bias fetch.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : pulse; (re)starts a load from entry 0
//   in_valid/in_data    : input stream, in_ready high while loading
//   busy, done          : load in progress / all DEPTH entries written
//   load_cnt            : words accepted in the current load
//   ra1, rd1            : read address / combinational read data
//   chk_expected,chk_err: expected checksum / mismatch flag
// Optional feature (macro BIAS_LOADER_CHECKSUM_EN): modulo-2^DATA_W running
// sum of accepted words, compared to chk_expected when the load completes.
// Without the macro chk_err is constant 0 and chk_expected is ignored.
// ----------------------------------------------------------------------------
module bias_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] load_cnt,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] chk_expected,
    output logic              chk_err
);

    import mlp_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic              accept;
    logic              last_word;

    // start wins over a same-cycle handshake: the word is dropped, not written.
    assign accept    = (state_q == LOAD) && in_valid && !start;
    assign last_word = accept && (load_cnt_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (start)          state_d = LOAD;
                else if (last_word) state_d = DONE;
            end
            DONE: if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = (state_q == LOAD);
        done     = (state_q == DONE);
    end

    always_comb begin
        load_cnt_d = load_cnt_q;
        if (start) begin
            load_cnt_d = '0;
        end else if (accept) begin
            load_cnt_d = load_cnt_q + 1'b1;
        end
    end

    assign load_cnt = load_cnt_q;

    regfile_bias_wr #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .wa    (load_cnt_q),
        .wd    (in_data),
        .ra1   (ra1),
        .rd1   (rd1)
    );

`ifdef BIAS_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              chk_err_q, chk_err_d;
    logic [DATA_W-1:0] sum_next;

    assign sum_next = sum_q + in_data;

    always_comb begin
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
        if (start) begin
            sum_d     = '0;
            chk_err_d = 1'b0;
        end else if (accept) begin
            sum_d = sum_next;
            // Final word is folded in here so the compare sees the full sum.
            if (last_word) begin
                chk_err_d = (sum_next != chk_expected);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_chk_expected;
    assign unused_chk_expected = ^chk_expected;
    assign chk_err = 1'b0;
`endif

endmodule
